// File: rtl/nrf_spi_responder.sv
// nrf_spi_responder
// SPI (mode 0) responder that behaves like the nRF24L01 command interface.
// It gives a controller a loop-back target without a radio attached.
// csn, sck and mosi are oversampled in the clk domain. STATUS goes out
// during the command byte, and register data is shifted out after it.
// Writes are committed to an internal register file and reported to fabric.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   csn/sck/mosi  SPI inputs (asynchronous to clk)
//   miso, miso_oe SPI data out and its drive enable
//   busy          transaction open
//   cmd_valid     one-clk pulse per completed command byte (cmd_byte holds it)
//   wr_strobe     one-clk pulse per committed write (wr_addr / wr_data)
//
// Optional build macro: NRF_RESP_STATUS_W1C_EN
//   When defined, STATUS bits 6:4 are write-1-to-clear and bits 3:0 are read-only.
//   When undefined, STATUS bits 6:0 are stored directly on a write.
module nrf_spi_responder #(
   parameter int          NUM_REGS    = 32,
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  STATUS_RST  = 8'h0E,
   parameter logic [7:0]  CONFIG_RST  = 8'h08
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       csn,
   input  logic       sck,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   output logic       busy,
   output logic       cmd_valid,
   output logic [7:0] cmd_byte,
   output logic       wr_strobe,
   output logic [4:0] wr_addr,
   output logic [7:0] wr_data
);

   typedef enum logic [2:0] {IDLE, CMD, RD, WR, IGN} state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync;
   logic                   csn_q, sck_q;
   logic                   csn_s, sck_s, mosi_s;
   logic                   csn_fall, csn_rise, sck_rise, sck_fall;

   logic [6:0] rx_sr;
   logic [7:0] rx_next;
   logic [7:0] tx_sr, tx_next;
   logic [2:0] bit_cnt;
   logic       byte_done;   // byte completed on the last rise; reload tx on next fall
   logic       byte_end;    // this rise completes a byte
   logic [4:0] addr;
   logic       addr_ok;
   logic [7:0] rd_val;
   logic [7:0] regs [32];

   // csn chain resets low, so a csn already low at reset release does not
   // open a transaction. A fresh fall is required.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csn_sync  <= '0;
         sck_sync  <= '0;
         mosi_sync <= '0;
         csn_q     <= 1'b0;
         sck_q     <= 1'b0;
      end else begin
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         csn_q     <= csn_sync[SYNC_STAGES-1];
         sck_q     <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign csn_s    = csn_sync[SYNC_STAGES-1];
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign csn_fall = csn_q & ~csn_s;
   assign csn_rise = ~csn_q & csn_s;
   assign sck_rise = ~sck_q & sck_s;
   assign sck_fall = sck_q & ~sck_s;

   assign rx_next  = {rx_sr, mosi_s};
   assign byte_end = sck_rise && (bit_cnt == 3'd7);
   assign addr_ok  = 32'(addr) < NUM_REGS;

   // Read data for an R_REGISTER decoded from the byte completing now
   always_comb begin
      rd_val = 8'h00;
      if (32'(rx_next[4:0]) < NUM_REGS) rd_val = regs[rx_next[4:0]];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == IDLE) begin
         if (csn_fall) state_nx = CMD;
      end else if (csn_rise) begin
         state_nx = IDLE;               // csn rise beats a same-clk sck rise
      end else if (byte_end) begin
         case (state)
            CMD: begin
               if (rx_next[7:5] == 3'b000)      state_nx = RD;
               else if (rx_next[7:5] == 3'b001) state_nx = WR;
               else                             state_nx = IGN;
            end
            WR:      state_nx = IGN;
            default: state_nx = state;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign miso_oe = (state != IDLE);
   assign miso    = tx_sr[7];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sr     <= '0;
         tx_sr     <= '0;
         tx_next   <= '0;
         bit_cnt   <= '0;
         byte_done <= 1'b0;
         addr      <= '0;
         cmd_valid <= 1'b0;
         cmd_byte  <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         for (int i = 0; i < 32; i++)
            regs[i] <= (i == 0) ? CONFIG_RST : (i == 7) ? STATUS_RST : 8'h00;
      end else begin
         cmd_valid <= 1'b0;
         wr_strobe <= 1'b0;
         if (state == IDLE) begin
            if (csn_fall) begin
               tx_sr     <= regs[7];
               rx_sr     <= '0;
               bit_cnt   <= '0;
               byte_done <= 1'b0;
            end
         end else if (csn_rise) begin
            tx_sr     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
         end else begin
            if (sck_rise) begin
               rx_sr   <= rx_next[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (byte_end) begin
                  byte_done <= 1'b1;
                  case (state)
                     CMD: begin
                        cmd_valid <= 1'b1;
                        cmd_byte  <= rx_next;
                        addr      <= rx_next[4:0];
                        tx_next   <= (rx_next[7:5] == 3'b000) ? rd_val : 8'h00;
                     end
                     WR: begin
                        tx_next <= 8'h00;
                        if (addr_ok) begin
                           wr_strobe <= 1'b1;
                           wr_addr   <= addr;
                           wr_data   <= rx_next;
                           for (int i = 0; i < 32; i++) begin
                              if (i < NUM_REGS && addr == 5'(i)) begin
                                 if (i == 7) begin
`ifdef NRF_RESP_STATUS_W1C_EN
                                    regs[i] <= {1'b0, regs[i][6:4] & ~rx_next[6:4], regs[i][3:0]};
`else
                                    regs[i] <= {1'b0, rx_next[6:0]};
`endif
                                 end else begin
                                    regs[i] <= rx_next;
                                 end
                              end
                           end
                        end
                     end
                     RD:      tx_next <= tx_next;   // same register every byte
                     default: tx_next <= 8'h00;
                  endcase
               end
            end
            if (sck_fall) begin
               if (byte_done) begin
                  tx_sr     <= tx_next;
                  byte_done <= 1'b0;
               end else begin
                  tx_sr <= {tx_sr[6:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_nrf_spi_responder.sv
module tb_nrf_spi_responder;
   localparam int HALF = 6;   // clk cycles per sck phase

   logic       clk = 1'b0;
   logic       reset;
   logic       csn, sck, mosi;
   logic       miso, miso_oe, busy, cmd_valid, wr_strobe;
   logic [7:0] cmd_byte, wr_data;
   logic [4:0] wr_addr;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  exp_cmd[$];
   logic [12:0] exp_wr[$];
   logic [7:0]  exp_miso[$];
   logic [7:0]  obs_miso[$];

   always #5 clk = ~clk;

   nrf_spi_responder #(.NUM_REGS(16)) dut (
      .clk(clk), .reset(reset), .csn(csn), .sck(sck), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .busy(busy),
      .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Monitor: compares every DUT output event against the scoreboard queues
   always @(negedge clk) begin
      if (cmd_valid) begin
         if (exp_cmd.size() == 0) chk("cmd_unexpected", {24'd0, cmd_byte}, 32'hFFFF_FFFF);
         else                     chk("cmd_byte", {24'd0, cmd_byte}, {24'd0, exp_cmd.pop_front()});
      end
      if (wr_strobe) begin
         if (exp_wr.size() == 0) chk("wr_unexpected", {19'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
         else                    chk("wr_addr_data", {19'd0, wr_addr, wr_data}, {19'd0, exp_wr.pop_front()});
      end
      if (obs_miso.size() > 0) begin
         if (exp_miso.size() == 0) chk("miso_unexpected", {24'd0, obs_miso.pop_front()}, 32'hFFFF_FFFF);
         else                      chk("miso_byte", {24'd0, obs_miso.pop_front()}, {24'd0, exp_miso.pop_front()});
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic cs_lo();
      csn = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_hi();
      wait_clk(HALF);
      csn = 1'b1;
      wait_clk(2 * HALF);
   endtask

   // Clock n bits of tx out and return what was sampled on miso
   task automatic bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         mosi = tx[7 - i];
         wait_clk(HALF);
         rx = {rx[6:0], miso};
         sck = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
      logic [7:0] rx;
      exp_miso.push_back(exp);
      bits(tx, 8, rx);
      obs_miso.push_back(rx);
   endtask

   logic [7:0] junk;
   logic [7:0] st_pre, st_post;

   initial begin
`ifdef NRF_RESP_STATUS_W1C_EN
      st_pre  = 8'h0E;
      st_post = 8'h0E;
`else
      st_pre  = 8'h7E;
      st_post = 8'h70;
`endif
      csn = 1'b1; sck = 1'b0; mosi = 1'b0; reset = 1'b1;
      wait_clk(4);
      @(negedge clk);
      chk("reset_outputs", {9'd0, miso, miso_oe, busy, cmd_valid, cmd_byte, wr_strobe, wr_addr, wr_data},
          32'd0);
      reset = 1'b0;
      wait_clk(4);

      // NOP returns STATUS
      exp_cmd.push_back(8'hFF);
      cs_lo();
      @(negedge clk);
      chk("busy_oe_open", {30'd0, busy, miso_oe}, 32'd3);
      xfer(8'hFF, 8'h0E);
      cs_hi();
      @(negedge clk);
      chk("busy_oe_closed", {29'd0, busy, miso_oe, miso}, 32'd0);

      // Write CONFIG, then read it back
      exp_cmd.push_back(8'h20); exp_wr.push_back({5'd0, 8'h0B});
      cs_lo(); xfer(8'h20, 8'h0E); xfer(8'h0B, 8'h00); cs_hi();
      exp_cmd.push_back(8'h00);
      cs_lo(); xfer(8'h00, 8'h0E); xfer(8'hFF, 8'h0B); cs_hi();

      // Repeated read of reg 5, write it, read again
      exp_cmd.push_back(8'h05);
      cs_lo(); xfer(8'h05, 8'h0E); xfer(8'hA5, 8'h00); xfer(8'h5A, 8'h00); xfer(8'hFF, 8'h00); cs_hi();
      exp_cmd.push_back(8'h25); exp_wr.push_back({5'd5, 8'h4C});
      cs_lo(); xfer(8'h25, 8'h0E); xfer(8'h4C, 8'h00); cs_hi();
      exp_cmd.push_back(8'h05);
      cs_lo(); xfer(8'h05, 8'h0E); xfer(8'h00, 8'h4C); xfer(8'h00, 8'h4C); xfer(8'h00, 8'h4C); cs_hi();

      // Unimplemented address: no write, reads 0
      exp_cmd.push_back(8'h3F);
      cs_lo(); xfer(8'h3F, 8'h0E); xfer(8'hAA, 8'h00); cs_hi();
      exp_cmd.push_back(8'h1F);
      cs_lo(); xfer(8'h1F, 8'h0E); xfer(8'h00, 8'h00); cs_hi();

      // Partial data byte aborted by csn
      exp_cmd.push_back(8'h21);
      cs_lo(); xfer(8'h21, 8'h0E); bits(8'hC3, 4, junk); cs_hi();
      exp_cmd.push_back(8'h01);
      cs_lo(); xfer(8'h01, 8'h0E); xfer(8'h00, 8'h00); cs_hi();
      exp_cmd.push_back(8'hFF);
      cs_lo(); xfer(8'hFF, 8'h0E); cs_hi();

      // STATUS writes (plain store vs W1C)
      exp_cmd.push_back(8'h27); exp_wr.push_back({5'd7, 8'h7E});
      cs_lo(); xfer(8'h27, 8'h0E); xfer(8'h7E, 8'h00); cs_hi();
      exp_cmd.push_back(8'hFF);
      cs_lo(); xfer(8'hFF, st_pre); cs_hi();
      exp_cmd.push_back(8'h27); exp_wr.push_back({5'd7, 8'h70});
      cs_lo(); xfer(8'h27, st_pre); xfer(8'h70, 8'h00); cs_hi();
      exp_cmd.push_back(8'h07);
      cs_lo(); xfer(8'h07, st_post); xfer(8'h00, st_post); cs_hi();

      // Reset mid-transaction: no activity until a fresh csn fall
      cs_lo(); bits(8'h20, 3, junk);
      reset = 1'b1;
      wait_clk(2);
      reset = 1'b0;
      bits(8'hFF, 8, junk);
      @(negedge clk);
      chk("idle_after_mid_reset", {29'd0, busy, miso_oe, miso}, 32'd0);
      cs_hi();
      exp_cmd.push_back(8'h00);
      cs_lo(); xfer(8'h00, 8'h0E); xfer(8'h00, 8'h08); cs_hi();

      wait_clk(4);
      chk("exp_cmd_drained", exp_cmd.size(), 0);
      chk("exp_wr_drained", exp_wr.size(), 0);
      chk("exp_miso_drained", exp_miso.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      wait_clk(60000);
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
